gpu_apb_master: RTL and testbench

APB initiator that feeds the GPU's APB command port. Upstream logic (CPU bridge or command sequencer) pushes address/data command words into an internal FIFO. The block replays each word as a two-phase APB write (SETUP, then ACCESS) on the pAddr/pDataWrite/pSel/pEnable/pWrite bus into the GPU. The block does not interpret the payload: opcode and parameter packing is owned by the GPU decoder.

---
 rtl/gpu_pkg.sv | 19 +
 rtl/gpu_cmd_fifo.sv | 51 +++++
 rtl/gpu_apb_master.sv | 127 ++++++++++++
 tb/tb_gpu_apb_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU APB command path.
package gpu_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    GAP    = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] data;
  } gpu_cmd_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO; the caller guarantees no push when full and no pop when empty.
module gpu_cmd_fifo
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  gpu_cmd_t      i_cmd,
  input  logic          i_pop,
  output gpu_cmd_t      o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  gpu_cmd_t      r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_cmd;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(FIFO_DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/gpu_apb_master.sv
// APB write initiator replaying queued GPU command words as SETUP/ACCESS pairs.
// Optional inter-transfer throttle gap enabled by GPU_APB_MASTER_GAP_EN.
module gpu_apb_master
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [APB_AW-1:0] cmd_addr_i,
  input  logic [APB_DW-1:0] cmd_data_i,
  output logic [APB_AW-1:0] pAddr_o,
  output logic [APB_DW-1:0] pDataWrite_o,
  output logic              pSel_o,
  output logic              pEnable_o,
  output logic              pWrite_o,
  output logic              idle_o,
  output logic [LW-1:0]     level_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_param
    $error("gpu_apb_master: illegal FIFO_DEPTH or GAP_CYCLES");
  end

  apb_state_t        r_state;
  logic [APB_AW-1:0] r_paddr;
  logic [APB_DW-1:0] r_pdata;
  logic              r_psel;
  logic              r_pen;
  logic              r_pwrite;
  gpu_cmd_t          w_head;
  gpu_cmd_t          w_cmd;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_launch;

`ifdef GPU_APB_MASTER_GAP_EN
  logic [7:0] r_gap;
  assign w_launch = (r_state == IDLE) || (r_state == GAP && r_gap <= 8'd1);
`else
  assign w_launch = (r_state == IDLE) || (r_state == ACCESS);
`endif

  assign w_push    = cmd_valid_i && !w_full;
  assign w_pop     = w_launch && !w_empty;
  assign w_cmd     = '{addr: cmd_addr_i, data: cmd_data_i};

  gpu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_cmd   (w_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_paddr  <= '0;
      r_pdata  <= '0;
      r_psel   <= 1'b0;
      r_pen    <= 1'b0;
      r_pwrite <= 1'b0;
`ifdef GPU_APB_MASTER_GAP_EN
      r_gap    <= '0;
`endif
    end else begin
      if (w_pop) begin
        r_paddr <= w_head.addr;
        r_pdata <= w_head.data;
      end
      case (r_state)
        SETUP: begin
          r_state <= ACCESS;
          r_pen   <= 1'b1;
        end
`ifdef GPU_APB_MASTER_GAP_EN
        ACCESS: begin
          r_state  <= GAP;
          r_gap    <= GAP_CYCLES[7:0];
          r_psel   <= 1'b0;
          r_pen    <= 1'b0;
          r_pwrite <= 1'b0;
        end
        GAP: begin
          // Counter decrements to zero across exactly GAP_CYCLES idle cycles.
          if (r_gap > 8'd1) begin
            r_gap <= r_gap - 8'd1;
          end else begin
            r_gap    <= '0;
            r_state  <= w_empty ? IDLE : SETUP;
            r_psel   <= !w_empty;
            r_pwrite <= !w_empty;
          end
        end
`endif
        default: begin
          // IDLE, and ACCESS when there is no gap: launch the next entry if any.
          r_state  <= w_empty ? IDLE : SETUP;
          r_psel   <= !w_empty;
          r_pen    <= 1'b0;
          r_pwrite <= !w_empty;
        end
      endcase
    end
  end

  assign cmd_ready_o  = !w_full;
  assign pAddr_o      = r_paddr;
  assign pDataWrite_o = r_pdata;
  assign pSel_o       = r_psel;
  assign pEnable_o    = r_pen;
  assign pWrite_o     = r_pwrite;
  assign idle_o       = w_empty && (r_state == IDLE);

endmodule

// File: tb/tb_gpu_apb_master.sv
// Bench for gpu_apb_master: transfer-schedule reference model, directed cases, random traffic.
module tb_gpu_apb_master;
  localparam int DEPTH   = 4;
  localparam int GAP_CYC = 3;
`ifdef GPU_APB_MASTER_GAP_EN
  localparam int GAP = GAP_CYC;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready_o;
  logic [31:0] pAddr_o, pDataWrite_o;
  logic        pSel_o, pEnable_o, pWrite_o, idle_o;
  logic [2:0]  level_o;

  gpu_apb_master #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr),
    .cmd_data_i   (cmd_data),
    .pAddr_o      (pAddr_o),
    .pDataWrite_o (pDataWrite_o),
    .pSel_o       (pSel_o),
    .pEnable_o    (pEnable_o),
    .pWrite_o     (pWrite_o),
    .idle_o       (idle_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each queued command launches (SETUP) at the first edge that is
  // strictly after its acceptance and at least 2+GAP edges after the previous launch.
  int          q_acc[$];
  logic [31:0] q_a[$];
  logic [31:0] q_d[$];
  logic [31:0] m_a = '0, m_d = '0;
  int          last_s = -1000;
  int          m_writes = 0, dut_writes = 0;

  always @(posedge clk) begin
    int sz;
    sz = q_acc.size();
    cyc++;
    if (rst) begin
      q_acc.delete(); q_a.delete(); q_d.delete();
      m_a = '0; m_d = '0; last_s = -1000;
    end else begin
      if (sz > 0 && q_acc[0] < cyc && cyc >= last_s + 2 + GAP) begin
        m_a = q_a.pop_front();
        m_d = q_d.pop_front();
        void'(q_acc.pop_front());
        last_s = cyc;
      end
      if (cmd_valid && sz < DEPTH) begin
        q_acc.push_back(cyc);
        q_a.push_back(cmd_addr);
        q_d.push_back(cmd_data);
      end
    end
  end

  always @(negedge clk) begin
    bit su, ac;
    if (cyc > 0) begin
      su = (last_s == cyc);
      ac = (last_s == cyc - 1);
      check("pSel",        32'(pSel_o),      32'(su || ac));
      check("pEnable",     32'(pEnable_o),   32'(ac));
      check("pWrite",      32'(pWrite_o),    32'(su || ac));
      check("pAddr",       pAddr_o,          m_a);
      check("pDataWrite",  pDataWrite_o,     m_d);
      check("cmd_ready",   32'(cmd_ready_o), 32'(q_acc.size() < DEPTH));
      check("level",       32'(level_o),     32'(q_acc.size()));
      check("idle",        32'(idle_o),      32'(q_acc.size() == 0 && cyc > last_s + 1 + GAP));
      if (ac) m_writes++;
      if (pSel_o && pEnable_o) dut_writes++;
    end
  end

  a_en_sel: assert property (@(posedge clk) disable iff (rst) pEnable_o |-> pSel_o);
  a_stable: assert property (@(posedge clk) disable iff (rst)
                             (pSel_o && !pEnable_o) |=> ($stable(pAddr_o) && $stable(pDataWrite_o)));

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while (!idle_o && t < 60) begin @(negedge clk); t++; end
    check(name, 32'(idle_o), 32'd1);
  endtask

  initial begin
    int n_psel, first_i, last_i, n_acc, w0, k;
    logic [31:0] acc_data[$];
    bit saw_full, found;

    repeat (2) @(negedge clk);
    check("reset_ready", 32'(cmd_ready_o), 32'd1);
    check("reset_idle",  32'(idle_o),      32'd1);
    check("reset_psel",  32'(pSel_o),      32'd0);
    check("reset_level", 32'(level_o),     32'd0);
    rst = 1'b0;

    // Single command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0; cmd_data = 32'h1234_5678;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("single_k_level", 32'(level_o), 32'd1);
    check("single_k_idle",  32'(idle_o),  32'd0);
    @(negedge clk);
    check("single_setup_sel", 32'(pSel_o),    32'd1);
    check("single_setup_en",  32'(pEnable_o), 32'd0);
    check("single_setup_dat", pDataWrite_o,   32'h1234_5678);
    @(negedge clk);
    check("single_acc_sel", 32'(pSel_o),    32'd1);
    check("single_acc_en",  32'(pEnable_o), 32'd1);
    check("single_acc_adr", pAddr_o,        32'h0);
    check("single_acc_dat", pDataWrite_o,   32'h1234_5678);
    @(negedge clk);
    check("single_end_sel",  32'(pSel_o), 32'd0);
    check("single_end_idle", 32'(idle_o), 32'd1);

    // Four back-to-back pushes.
    n_psel = 0; first_i = -1; last_i = -1; acc_data.delete();
    for (int i = 0; i < 14 + 4 * GAP; i++) begin
      @(negedge clk);
      if (pSel_o) begin
        check("b2b_en_pattern", 32'(pEnable_o), 32'(n_psel % 2));
        if (first_i < 0) first_i = i;
        last_i = i;
        n_psel++;
        if (pEnable_o) acc_data.push_back(pDataWrite_o);
      end
      cmd_valid = (i < 4);
      cmd_addr  = 32'h100 + 32'(i);
      cmd_data  = 32'(i + 1);
    end
    cmd_valid = 1'b0;
    check("b2b_psel_cycles", 32'(n_psel), 32'd8);
    if (GAP == 0) check("b2b_contiguous", 32'(last_i - first_i), 32'd7);
    check("b2b_writes", 32'(acc_data.size()), 32'd4);
    for (int j = 0; j < acc_data.size(); j++) check("b2b_order", acc_data[j], 32'(j + 1));
    drain("b2b_drain");

    // Saturating push on every cycle.
    w0 = dut_writes; n_acc = 0; saw_full = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = $urandom;
      cmd_data  = $urandom;
      if (level_o == 3'(DEPTH)) saw_full = 1;
      if (cmd_ready_o) n_acc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("full_reached", 32'(saw_full), 32'd1);
    drain("full_drain");
    check("full_writes_eq_accepts", 32'(dut_writes - w0), 32'(n_acc));

    // Reset during ACCESS of the second of three queued commands.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 32'h200 + 32'(i); cmd_data = 32'hA1 + 32'(i);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 0; k = 0;
    while (!found && k < 40) begin
      if (pSel_o && pEnable_o && pDataWrite_o == 32'hA2) found = 1;
      else begin @(negedge clk); k++; end
    end
    check("rst_found_access", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_psel",  32'(pSel_o),      32'd0);
    check("rst_level", 32'(level_o),     32'd0);
    check("rst_ready", 32'(cmd_ready_o), 32'd1);
    w0 = dut_writes;
    repeat (8 + GAP) @(negedge clk);
    check("rst_no_more_writes", 32'(dut_writes), 32'(w0));

    // Random traffic with varying offered load.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 99) < ((i / 1000) % 4) * 30 + 10);
      cmd_addr  = $urandom;
      cmd_data  = $urandom;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    drain("rand_drain");
    check("total_writes", 32'(dut_writes), 32'(m_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
